// File: rtl/ram_sp_pkg.sv
// Shared types and helpers for the ram_sp_ctrl single-port RAM block.
package ram_sp_pkg;

  // Controller states: CLEAR zeroes the array after reset, IDLE serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Supported read latencies (accept edge to rvalid).
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest word the parity helper handles; callers cast down to DW/8 lanes.
  localparam int PAR_MAX_DW    = 1024;
  localparam int PAR_MAX_LANES = PAR_MAX_DW / 8;

  // Even parity per byte lane for the low dw bits of word; unused lanes are 0.
  function automatic logic [PAR_MAX_LANES-1:0] byte_parity(
    input logic [PAR_MAX_DW-1:0] word,
    input int                    dw
  );
    logic [PAR_MAX_LANES-1:0] p;
    p = '0;
    for (int i = 0; i < PAR_MAX_LANES; i++) begin
      if (i < dw / 8) p[i] = ^word[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/ram_sp_rdpipe.sv
// Read-return pipeline for ram_sp_ctrl: RD_LAT stages carrying the valid flag
// and read word. With RAM_PARITY_EN defined it also carries the stored parity
// vector and flags a mismatch in the rvalid cycle; otherwise perr is tied to 0.
module ram_sp_rdpipe
  import ram_sp_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_word,
`ifdef RAM_PARITY_EN
  input  logic [DW/8-1:0] in_par,
`endif
  output logic            rvalid,
  output logic [DW-1:0]   rdata,
  output logic            perr
);

  logic [RD_LAT-1:0] vld;
  logic [DW-1:0]     dat [RD_LAT];

  // Valid shift register; reset empties the pipeline immediately.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the value its neighbour held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // Data shift register.
  // NOTE: payload registers carry no reset; the valid flag alone says whether
  // they hold anything meaningful, so resetting them would only cost logic.
  always_ff @(posedge clk) begin
    dat[0] <= in_word;
    for (int i = 1; i < RD_LAT; i++) dat[i] <= dat[i-1];
  end

  assign rvalid = vld[RD_LAT-1];
  assign rdata  = dat[RD_LAT-1];

`ifdef RAM_PARITY_EN
  localparam int NL = DW / 8;

  logic [NL-1:0] par [RD_LAT];

  // Parity shift register, aligned with the data stages.
  always_ff @(posedge clk) begin
    par[0] <= in_par;
    for (int i = 1; i < RD_LAT; i++) par[i] <= par[i-1];
  end

  assign perr = rvalid & (|(NL'(byte_parity(PAR_MAX_DW'(rdata), DW)) ^ par[RD_LAT-1]));
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port synchronous RAM with req/ready handshake, byte-lane writes,
// RD_LAT-cycle pipelined reads and a shared tri-state data bus. After reset a
// clear sequencer writes zero to every word before ready rises.
// Optional feature macro: RAM_PARITY_EN adds one even-parity bit per stored
// byte and reports mismatches on perr during the rvalid cycle.
module ram_sp_ctrl
  import ram_sp_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 18,
  parameter int DEPTH  = 2**AW,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  inout  wire  [DW-1:0]   data,
  output logic            ready,
  output logic            rvalid,
  output logic            perr
);

  localparam int NL = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  if (DW < 8 || DW % 8 != 0) begin : g_bad_dw
    $error("ram_sp_ctrl: DW must be a positive multiple of 8");
  end
  if (DEPTH < 2 || DEPTH > 2**AW) begin : g_bad_depth
    $error("ram_sp_ctrl: DEPTH must be in 2..2**AW");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("ram_sp_ctrl: RD_LAT must be 1 or 2");
  end

  state_t        state, state_nx;
  logic [IW-1:0] clr_cnt;
  logic          clr_last;
  logic          addr_ok;
  logic [IW-1:0] widx;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] rd_word, rd_data;

  // Storage array; zeroed by the clear sequencer, never by reset.
  logic [DW-1:0] mem [DEPTH];

`ifdef RAM_PARITY_EN
  if (DW > PAR_MAX_DW) begin : g_bad_par_dw
    $error("ram_sp_ctrl: DW too wide for byte_parity");
  end

  logic [NL-1:0] par_mem [DEPTH];
  logic [NL-1:0] wpar, rd_par;

  assign wpar = NL'(byte_parity(PAR_MAX_DW'(data), DW));
`endif

  assign clr_last = (clr_cnt == IW'(DEPTH - 1));
  assign addr_ok  = ({1'b0, addr} < DEPTH_L);
  assign widx     = addr[IW-1:0];

  // The bus belongs to the block while rvalid is high, so writes wait it out.
  assign wr_acc = req & we & ready & ~rvalid;
  assign rd_acc = req & ~we & ready;

  // State register and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + IW'(1);
    end
  end

  // Next-state and ready decode; ready depends on the state register only.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      CLEAR:   if (clr_last) state_nx = IDLE;
      IDLE:    ready = 1'b1;
      default: state_nx = CLEAR;
    endcase
  end

  // Array writes: zero fill while clearing, byte-lane writes once idle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
`ifdef RAM_PARITY_EN
      par_mem[clr_cnt] <= '0;
`endif
    end else if (wr_acc && addr_ok) begin
      for (int i = 0; i < NL; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= data[8*i +: 8];
`ifdef RAM_PARITY_EN
          par_mem[widx][i] <= wpar[i];
`endif
        end
      end
    end
  end

  // Read word fetched at the accept edge; out-of-range addresses return zero.
  always_comb begin
    rd_word = '0;
`ifdef RAM_PARITY_EN
    rd_par  = '0;
`endif
    if (addr_ok) begin
      rd_word = mem[widx];
`ifdef RAM_PARITY_EN
      rd_par  = par_mem[widx];
`endif
    end
  end

  ram_sp_rdpipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_acc),
    .in_word  (rd_word),
`ifdef RAM_PARITY_EN
    .in_par   (rd_par),
`endif
    .rvalid   (rvalid),
    .rdata    (rd_data),
    .perr     (perr)
  );

  // Output enable comes from the registered rvalid only.
  assign data = rvalid ? rd_data : {DW{1'bz}};

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Directed bench for ram_sp_ctrl. Instance a: DEPTH=16, RD_LAT=2.
// Instance b: DEPTH=12 (out-of-range window), RD_LAT=1. Both share clk/rst_n.
module tb_ram_sp_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Instance a signals
  logic        req_a = 1'b0, we_a = 1'b0, drv_a = 1'b0;
  logic [1:0]  be_a = '0;
  logic [3:0]  addr_a = '0;
  logic [15:0] wd_a = '0;
  wire  [15:0] data_a;
  logic        ready_a, rvalid_a, perr_a;
  wire         hiz_a = (data_a === 16'bz);

  // Instance b signals
  logic        req_b = 1'b0, we_b = 1'b0, drv_b = 1'b0;
  logic [1:0]  be_b = '0;
  logic [3:0]  addr_b = '0;
  logic [15:0] wd_b = '0;
  wire  [15:0] data_b;
  logic        ready_b, rvalid_b, perr_b;
  wire         hiz_b = (data_b === 16'bz);

  // The master drives write data only while the block does not own the bus.
  assign data_a = (drv_a && !rvalid_a) ? wd_a : 16'bz;
  assign data_b = (drv_b && !rvalid_b) ? wd_b : 16'bz;

  ram_sp_ctrl #(.DW(16), .AW(4), .DEPTH(16), .RD_LAT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .be(be_a), .addr(addr_a),
    .data(data_a), .ready(ready_a), .rvalid(rvalid_a), .perr(perr_a)
  );

  ram_sp_ctrl #(.DW(16), .AW(4), .DEPTH(12), .RD_LAT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .be(be_b), .addr(addr_b),
    .data(data_b), .ready(ready_b), .rvalid(rvalid_b), .perr(perr_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rv(input bit sel);
    return sel ? rvalid_b : rvalid_a;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? ready_b : ready_a;
  endfunction

  function automatic logic pe(input bit sel);
    return sel ? perr_b : perr_a;
  endfunction

  function automatic logic hz(input bit sel);
    return sel ? hiz_b : hiz_a;
  endfunction

  function automatic logic [15:0] rd(input bit sel);
    return sel ? data_b : data_a;
  endfunction

  task automatic drive(input bit sel, input logic r, input logic w, input logic [1:0] b,
                       input logic [3:0] a, input logic [15:0] d);
    if (sel) begin
      req_b = r; we_b = w; be_b = b; addr_b = a; wd_b = d; drv_b = r & w;
    end else begin
      req_a = r; we_a = w; be_a = b; addr_a = a; wd_a = d; drv_a = r & w;
    end
  endtask

  // Write held until the master sees ready & ~rvalid before an edge.
  task automatic do_write(input bit sel, input logic [3:0] a, input logic [15:0] d,
                          input logic [1:0] b);
    logic ok, done;
    int   n;
    done = 1'b0;
    n    = 0;
    drive(sel, 1'b1, 1'b1, b, a, d);
    while (!done && n < 8) begin
      ok = rdy(sel) & ~rv(sel);
      tick();
      n++;
      done = ok;
    end
    check("wr_accept", done, 1'b1);
    drive(sel, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
  endtask

  // Single read: checks latency, data, perr and the one-cycle pulse.
  task automatic do_read(input bit sel, input logic [3:0] a, input logic [15:0] exp,
                         input int lat, input logic exp_perr);
    int n;
    drive(sel, 1'b1, 1'b0, 2'b00, a, 16'h0);
    tick();
    drive(sel, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    n = 1;
    while (!rv(sel) && n < 8) begin
      tick();
      n++;
    end
    check("rd_lat", n, lat);
    check("rd_data", rd(sel), exp);
    check("rd_perr", pe(sel), exp_perr);
    tick();
    check("rd_pulse", rv(sel), 1'b0);
    check("rd_hiz", hz(sel), 1'b1);
    check("rd_perr_idle", pe(sel), 1'b0);
  endtask

  initial begin
    int   n, na, nb;
    logic seen;

    // Reset state
    repeat (3) tick();
    check("rst_ready", ready_a, 1'b0);
    check("rst_rvalid", rvalid_a, 1'b0);
    check("rst_perr", perr_a, 1'b0);
    check("rst_hiz", hiz_a, 1'b1);
    check("rst_ready_b", ready_b, 1'b0);

    // Read requested during the clear window must never return rvalid
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen = seen | rvalid_a;
    end
    check("clr_no_rvalid", seen, 1'b0);
    check("clr_ready", ready_a, 1'b0);
    drive(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);

    // Reset pulse at clear cycle 7; clear restarts from zero
    rst_n = 1'b0;
    tick();
    tick();
    check("pulse_ready", ready_a, 1'b0);
    rst_n = 1'b1;
    n  = 0;
    na = 0;
    nb = 0;
    while ((!ready_a || !ready_b) && n < 40) begin
      tick();
      n++;
      if (ready_a && na == 0) na = n;
      if (ready_b && nb == 0) nb = n;
    end
    check("clr_len_a", na, 16);
    check("clr_len_b", nb, 12);

    // Whole array reads back zero
    for (int i = 0; i < 16; i++) do_read(0, 4'(i), 16'h0000, 2, 1'b0);

    // Byte-lane writes
    do_write(0, 4'd3, 16'hA5C3, 2'b11);
    do_write(0, 4'd3, 16'hFF00, 2'b01);
    do_read(0, 4'd3, 16'hA500, 2, 1'b0);
    do_write(0, 4'd3, 16'hBEEF, 2'b00);
    do_read(0, 4'd3, 16'hA500, 2, 1'b0);
    do_write(0, 4'd1, 16'h1111, 2'b11);
    do_write(0, 4'd2, 16'h2222, 2'b10);
    do_read(0, 4'd2, 16'h2200, 2, 1'b0);

    // Back-to-back reads of 1, 2, 3
    drive(0, 1'b1, 1'b0, 2'b00, 4'd1, 16'h0);
    tick();
    check("b2b_rv0", rvalid_a, 1'b0);
    check("b2b_hiz0", hiz_a, 1'b1);
    drive(0, 1'b1, 1'b0, 2'b00, 4'd2, 16'h0);
    tick();
    check("b2b_rv1", rvalid_a, 1'b1);
    check("b2b_d1", data_a, 16'h1111);
    drive(0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    tick();
    check("b2b_rv2", rvalid_a, 1'b1);
    check("b2b_d2", data_a, 16'h2200);
    drive(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    tick();
    check("b2b_rv3", rvalid_a, 1'b1);
    check("b2b_d3", data_a, 16'hA500);
    tick();
    check("b2b_rv_end", rvalid_a, 1'b0);
    check("b2b_hiz_end", hiz_a, 1'b1);

    // Write presented while rvalid=1 waits one cycle
    drive(0, 1'b1, 1'b0, 2'b00, 4'd1, 16'h0);
    tick();
    drive(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    tick();
    check("hold_rv", rvalid_a, 1'b1);
    drive(0, 1'b1, 1'b1, 2'b11, 4'd7, 16'h7777);
    tick();
    check("hold_mem", u_a.mem[7], 16'h0000);
    check("hold_rv_lo", rvalid_a, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    check("held_mem", u_a.mem[7], 16'h7777);
    do_read(0, 4'd7, 16'h7777, 2, 1'b0);

    // Out-of-range handling on the DEPTH=12 instance
    do_read(1, 4'd5, 16'h0000, 1, 1'b0);
    do_write(1, 4'd13, 16'h1234, 2'b11);
    do_read(1, 4'd13, 16'h0000, 1, 1'b0);
    do_write(1, 4'd11, 16'hCAFE, 2'b11);
    do_read(1, 4'd11, 16'hCAFE, 1, 1'b0);

`ifdef RAM_PARITY_EN
    u_b.par_mem[11] = u_b.par_mem[11] ^ 2'b01;
    do_read(1, 4'd11, 16'hCAFE, 1, 1'b1);
    do_read(1, 4'd10, 16'h0000, 1, 1'b0);
`endif

    // Reset mid-traffic drops rvalid and releases the bus at once
    drive(0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    tick();
    drive(0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
    tick();
    check("mid_rv", rvalid_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rv", rvalid_a, 1'b0);
    check("mid_rst_hiz", hiz_a, 1'b1);
    check("mid_rst_ready", ready_a, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", ready_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
